// File: rtl/bist_ctrl.sv
// bist_ctrl: BIST session controller and signature checker.
// Seeds the TPG/ORA, runs them for CYCLES edges, freezes them, then
// compares the captured ORA signature against GOLDEN.
module bist_ctrl #(
  parameter int unsigned    WIDTH  = 4,
  parameter int unsigned    CYCLES = 16,
  parameter int unsigned    CNT_W  = 5,
  parameter logic [WIDTH-1:0] GOLDEN = '0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] sig_in,
  output logic             sub_run,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [WIDTH-1:0] sig_out
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_CMP,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               done_nxt;
  logic               pass_nxt;
  logic               fail_nxt;
  logic [WIDTH-1:0]   sig_nxt;

  // State and result registers; rst_b wins over every other condition.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state   <= S_IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      sig_out <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      done    <= done_nxt;
      pass    <= pass_nxt;
      fail    <= fail_nxt;
      sig_out <= sig_nxt;
    end
  end

  // Next-state and next-result logic; results are cleared on entry to SEED
  // so done is high for exactly one cycle when start is held in DONE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = done;
    pass_nxt  = pass;
    fail_nxt  = fail;
    sig_nxt   = sig_out;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_SEED;
          cnt_nxt   = '0;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          fail_nxt  = 1'b0;
        end
      end
      S_SEED: begin
        cnt_nxt   = '0;
        state_nxt = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (cnt == LAST_CNT) begin
          state_nxt = S_CMP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_CMP: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DONE;
          sig_nxt   = sig_in;
          pass_nxt  = (sig_in == GOLDEN);
          fail_nxt  = (sig_in != GOLDEN);
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // TPG/ORA run enable and busy flag decode straight from the state register.
  assign sub_run = (state == S_RUN);
  assign busy    = (state == S_SEED) || (state == S_RUN) || (state == S_CMP);

endmodule

// File: tb/tb_bist_ctrl.sv
// tb_bist_ctrl: directed self-checking bench for bist_ctrl.
// u_a: CYCLES=4, GOLDEN=A; u_b: CYCLES=1; u_c: CYCLES=4 fed by a small
// TPG -> CUT -> MISR chain modelled in the bench.
module tb_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] sig_in = 4'h0;

  logic       a_sub_run, a_busy, a_done, a_pass, a_fail;
  logic [3:0] a_sig_out;
  logic       b_sub_run, b_busy, b_done, b_pass, b_fail;
  logic [3:0] b_sig_out;
  logic       c_sub_run, c_busy, c_done, c_pass, c_fail;
  logic [3:0] c_sig_out;

  logic [3:0] tpg = 4'h0;
  logic [3:0] misr = 4'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bist_ctrl #(.WIDTH(4), .CYCLES(4), .CNT_W(5), .GOLDEN(4'hA)) u_a (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort), .sig_in(sig_in),
    .sub_run(a_sub_run), .busy(a_busy), .done(a_done), .pass(a_pass),
    .fail(a_fail), .sig_out(a_sig_out));

  bist_ctrl #(.WIDTH(4), .CYCLES(1), .CNT_W(1), .GOLDEN(4'hA)) u_b (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort), .sig_in(sig_in),
    .sub_run(b_sub_run), .busy(b_busy), .done(b_done), .pass(b_pass),
    .fail(b_fail), .sig_out(b_sig_out));

  // Chain signature after 4 run edges from seed 0: 3, 4, 8, 1 -> 4'h1.
  bist_ctrl #(.WIDTH(4), .CYCLES(4), .CNT_W(3), .GOLDEN(4'h1)) u_c (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort), .sig_in(misr),
    .sub_run(c_sub_run), .busy(c_busy), .done(c_done), .pass(c_pass),
    .fail(c_fail), .sig_out(c_sig_out));

  // TPG counter, CUT = pattern ^ 3, 4-bit MISR; sub_run low reseeds both.
  always @(posedge clk) begin
    if (!c_sub_run) begin
      tpg  <= 4'h0;
      misr <= 4'h0;
    end else begin
      tpg  <= tpg + 4'h1;
      misr <= {misr[2:0], misr[3] ^ misr[2]} ^ (tpg ^ 4'h3);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after edge E0 (the edge that samples start).
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    step();
    step();
    rst_b = 1'b0;
    checks++;
    if ({a_sub_run, a_busy, a_done, a_pass, a_fail, a_sig_out} !== 9'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %b exp 000000000",
               {a_sub_run, a_busy, a_done, a_pass, a_fail, a_sig_out});
    end
  endtask

  task automatic test_cycles1();
    sig_in = 4'hA;
    pulse_start();
    checks++;
    if ({b_busy, b_sub_run} !== 2'b10) begin
      errors++; $display("FAIL c1_seed: got busy,sub_run=%b exp 10", {b_busy, b_sub_run});
    end
    step();
    checks++;
    if (b_sub_run !== 1'b1) begin
      errors++; $display("FAIL c1_run: got sub_run=%b exp 1", b_sub_run);
    end
    step();
    checks++;
    if ({b_sub_run, b_done} !== 2'b00) begin
      errors++; $display("FAIL c1_cmp: got sub_run,done=%b exp 00", {b_sub_run, b_done});
    end
    step();
    checks++;
    if ({b_done, b_pass, b_fail, b_busy, b_sig_out} !== 8'b1100_1010) begin
      errors++;
      $display("FAIL c1_done: got done,pass,fail,busy,sig=%b exp 11001010",
               {b_done, b_pass, b_fail, b_busy, b_sig_out});
    end
    repeat (3) step();
  endtask

  task automatic test_pass();
    int runs;
    int busys;
    runs = 0;
    busys = 0;
    sig_in = 4'hA;
    pulse_start();
    if (a_busy) busys++;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (a_sub_run) runs++;
      if (a_busy) busys++;
      if (k == 5) begin
        checks++;
        if (a_done !== 1'b0) begin
          errors++; $display("FAIL pass_early_done: got %b exp 0 at E0+5", a_done);
        end
      end
    end
    checks++;
    if (runs != 4) begin
      errors++; $display("FAIL pass_run_cycles: got %0d exp 4", runs);
    end
    checks++;
    if (busys != 6) begin
      errors++; $display("FAIL pass_busy_cycles: got %0d exp 6", busys);
    end
    checks++;
    if ({a_done, a_pass, a_fail, a_sig_out} !== 7'b110_1010) begin
      errors++;
      $display("FAIL pass_result: got done,pass,fail,sig=%b exp 1101010",
               {a_done, a_pass, a_fail, a_sig_out});
    end
  endtask

  task automatic test_fail();
    sig_in = 4'h5;
    pulse_start();
    checks++;
    if ({a_done, a_pass, a_fail} !== 3'b000) begin
      errors++; $display("FAIL fail_seed_clear: got done,pass,fail=%b exp 000", {a_done, a_pass, a_fail});
    end
    repeat (6) step();
    checks++;
    if ({a_done, a_pass, a_fail, a_sig_out} !== 7'b101_0101) begin
      errors++;
      $display("FAIL fail_result: got done,pass,fail,sig=%b exp 1010101",
               {a_done, a_pass, a_fail, a_sig_out});
    end
  endtask

  task automatic test_capture();
    sig_in = 4'h3;
    pulse_start();
    repeat (5) step();
    sig_in = 4'hA;
    step();
    checks++;
    if ({a_done, a_pass, a_sig_out} !== 6'b11_1010) begin
      errors++;
      $display("FAIL capture_edge: got done,pass,sig=%b exp 111010", {a_done, a_pass, a_sig_out});
    end
  endtask

  task automatic test_back_to_back();
    sig_in = 4'hA;
    pulse_start();
    repeat (2) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    checks++;
    if (a_done !== 1'b0) begin
      errors++; $display("FAIL ignore_start_early: got done=%b exp 0 at E0+5", a_done);
    end
    start = 1'b1;
    step();
    checks++;
    if ({a_done, a_pass} !== 2'b11) begin
      errors++; $display("FAIL ignore_start_done: got done,pass=%b exp 11 at E0+6", {a_done, a_pass});
    end
    step();
    start = 1'b0;
    checks++;
    if ({a_done, a_pass, a_fail, a_busy, a_sub_run} !== 5'b00010) begin
      errors++;
      $display("FAIL b2b_seed: got done,pass,fail,busy,sub_run=%b exp 00010",
               {a_done, a_pass, a_fail, a_busy, a_sub_run});
    end
    repeat (6) step();
    checks++;
    if ({a_done, a_pass, a_sig_out} !== 6'b11_1010) begin
      errors++;
      $display("FAIL b2b_second: got done,pass,sig=%b exp 111010", {a_done, a_pass, a_sig_out});
    end
  endtask

  task automatic test_chain();
    sig_in = 4'hA;
    pulse_start();
    repeat (6) step();
    checks++;
    if ({c_done, c_pass, c_fail, c_sig_out} !== 7'b110_0001) begin
      errors++;
      $display("FAIL chain_result: got done,pass,fail,sig=%b exp 1100001",
               {c_done, c_pass, c_fail, c_sig_out});
    end
  endtask

  task automatic test_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({a_done, a_pass} !== 2'b11) begin
      errors++; $display("FAIL abort_in_done: got done,pass=%b exp 11", {a_done, a_pass});
    end
    pulse_start();
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({a_sub_run, a_busy, a_done, a_pass, a_fail, a_sig_out} !== 9'b00000_1010) begin
      errors++;
      $display("FAIL abort_run: got sub_run,busy,done,pass,fail,sig=%b exp 000001010",
               {a_sub_run, a_busy, a_done, a_pass, a_fail, a_sig_out});
    end
    repeat (6) step();
    checks++;
    if ({a_busy, a_done} !== 2'b00) begin
      errors++; $display("FAIL abort_stay_idle: got busy,done=%b exp 00", {a_busy, a_done});
    end
  endtask

  task automatic test_reset_mid_run();
    sig_in = 4'hA;
    pulse_start();
    repeat (2) step();
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    checks++;
    if ({a_sub_run, a_busy, a_done, a_pass, a_fail, a_sig_out} !== 9'h000) begin
      errors++;
      $display("FAIL reset_mid_run: got %b exp 000000000",
               {a_sub_run, a_busy, a_done, a_pass, a_fail, a_sig_out});
    end
  endtask

  initial begin
    test_reset();
    test_cycles1();
    test_pass();
    test_fail();
    test_capture();
    test_back_to_back();
    test_chain();
    test_abort();
    test_pass();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
